// File: rtl/noc_ring_input_unit_pkg.sv
// noc_ring_input_unit_pkg: shared ring NoC types, ring indexing and route computation
// NOC_RING_SHORTEST_PATH_EN selects bidirectional shortest-path routing; otherwise the ring is East-only.
package noc_ring_input_unit_pkg;

    localparam int xMax = 8;
    localparam int yMax = 8;
    localparam int xWidth = $clog2(xMax);
    localparam int yWidth = $clog2(yMax);
    localparam int ringSize = xMax * yMax;
    localparam int ringIdxWidth = $clog2(ringSize);

    typedef struct packed {
        logic [yWidth-1:0] y;
        logic [xWidth-1:0] x;
    } xy_t;

    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    typedef logic [2:0] direction_t;

    localparam direction_t goLocal = 3'b001;
    localparam direction_t goEast  = 3'b010;
    localparam direction_t goWest  = 3'b100;

    typedef enum logic {
        kFlowControlAckNack,
        kFlowControlCredit
    } noc_flow_control_t;

    function automatic logic [ringIdxWidth-1:0] xy2ring_idx(xy_t xy);
        return ringIdxWidth'(xy.y) * ringIdxWidth'(xMax) + ringIdxWidth'(xy.x);
    endfunction

    // Clockwise distance wraps naturally in ringIdxWidth bits.
    function automatic direction_t ring_route(xy_t cur, xy_t dst);
        logic [ringIdxWidth-1:0] d;
        d = xy2ring_idx(dst) - xy2ring_idx(cur);
`ifdef NOC_RING_SHORTEST_PATH_EN
        return d == '0 ? goLocal : ({1'b0, d} <= (ringIdxWidth+1)'(ringSize / 2)) ? goEast : goWest;
`else
        return d == '0 ? goLocal : goEast;
`endif
    endfunction

endpackage

// File: rtl/noc_ring_input_unit_fifo.sv
// noc_ring_input_unit_fifo: power-of-two flit FIFO with push/pop handshake and occupancy count
module noc_ring_input_unit_fifo #(
    parameter int Depth = 4,
    parameter int DataWidth = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DataWidth-1:0]    wdata,
    output logic [DataWidth-1:0]    rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(Depth):0]  count,
    output logic                    push_ok,
    output logic                    pop_ok
);

    localparam int AddrWidth = $clog2(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [AddrWidth-1:0] wr_ptr, rd_ptr;

    assign full    = count == (AddrWidth+1)'(Depth);
    assign empty   = count == '0;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= wdata;

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AddrWidth'(push_ok);
            rd_ptr <= rd_ptr + AddrWidth'(pop_ok);
            count  <= count + (AddrWidth+1)'(push_ok) - (AddrWidth+1)'(pop_ok);
        end

endmodule

// File: rtl/noc_ring_input_unit.sv
// noc_ring_input_unit: ring router input port - flit FIFO, per-packet route hold, ack/nack or credit flow control
// NOC_RING_SHORTEST_PATH_EN (in the package) enables West routing for the shorter way round the ring.
module noc_ring_input_unit
    import noc_ring_input_unit_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter int Depth = 4,
    parameter noc_flow_control_t FlowControl = kFlowControlAckNack
) (
    input  logic                 clk,
    input  logic                 rst,
    input  xy_t                  position,
    input  logic [DataWidth-1:0] data_in,
    input  logic                 data_void_in,
    output logic                 stop_out,
    output logic                 credit_out,
    output logic [DataWidth-1:0] data_out,
    output logic                 data_void_out,
    output direction_t           route_out,
    input  logic                 stop_in,
    output logic                 overflow_out
);

    localparam int CountWidth = $clog2(Depth) + 1;

    logic full, empty, push_ok, pop_ok;
    logic [CountWidth-1:0] count, count_next;
    preamble_t pre;
    xy_t dst;
    direction_t head_route, route_q;

    noc_ring_input_unit_fifo #(
        .Depth(Depth),
        .DataWidth(DataWidth)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(!data_void_in),
        .pop(!stop_in),
        .wdata(data_in),
        .rdata(data_out),
        .full(full),
        .empty(empty),
        .count(count),
        .push_ok(push_ok),
        .pop_ok(pop_ok)
    );

    assign pre           = data_out[DataWidth-1 -: 2];
    assign dst           = data_out[DataWidth-3 -: yWidth+xWidth];
    assign head_route    = ring_route(position, dst);
    assign route_out     = empty ? '0 : pre.head ? head_route : route_q;
    assign data_void_out = empty;
    assign count_next    = count + CountWidth'(push_ok) - CountWidth'(pop_ok);

    // Hold the packet route from a multi-flit head until its tail; register flow control and the sticky overflow.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            route_q    <= '0;
            stop_out   <= 1'b0;
            credit_out <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            if (pop_ok && pre.head && !pre.tail) route_q <= head_route;
            stop_out   <= FlowControl == kFlowControlAckNack && count_next >= CountWidth'(Depth - 1);
            credit_out <= FlowControl == kFlowControlCredit && pop_ok;
            overflow_out <= overflow_out | (!data_void_in && full && !pop_ok);
        end

endmodule

// File: doc/noc_ring_input_unit.md
# noc_ring_input_unit

Input stage of one ring-router port (East, West or Local). It buffers incoming flits in a small FIFO and generates upstream flow control (ack/nack stop or credit return). For each packet it computes the one-hot output direction on the ring and presents that route, together with the head-of-queue flit, to the router's switch allocator/crossbar downstream. The route is held from head to tail, so body and tail flits follow their head.

## Interface
- `DataWidth`, 64: flit width. Bits [DataWidth-1:DataWidth-2] are `preamble_t` {head, tail}. Head flits carry destination `xy_t` in [DataWidth-3 -: yWidth+xWidth].
- `Depth`, 4: FIFO entries; power of two, ≥2.
- `FlowControl`, `kFlowControlAckNack`: `noc_flow_control_t` mode.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `position`  in  `xy_t`  this router's coordinates; quasi-static.
- `data_in`  in  DataWidth  incoming flit.
- `data_void_in`  in  1  1 = no flit this cycle.
- `stop_out`  out  1  ack/nack mode: upstream must not send. Tied 0 in credit mode.
- `credit_out`  out  1  credit mode: one-cycle pulse per freed entry. Tied 0 in ack/nack mode.
- `data_out`  out  DataWidth  flit at FIFO head.
- `data_void_out`  out  1  1 = FIFO empty.
- `route_out`  out  `direction_t`  one-hot destination port for `data_out`; 0 when void.
- `stop_in`  in  1  downstream refuses the flit this cycle.
- `overflow_out`  out  1  sticky: a flit arrived while full.

## Operation
- Ring index is idx = y·xMax + x, with N = xMax·yMax = 64. Clockwise (East) distance is d = (dst_idx − cur_idx) mod N, computed in 6 bits with natural wrap.
- Route for a head flit:
  - d = 0 → `goLocal`
  - otherwise East/West as selected by the macro (see Configuration).
- Route register:
  - When a head flit is dequeued, its computed route is latched.
  - Body/tail flits at the head of the FIFO show the latched route.
  - A flit with head=tail=1 (single-flit packet) uses its own computed route and does not need to update the latch.
- Enqueue: `data_void_in`=0 and not full → write at tail pointer, count+1.
- Dequeue: not empty and `stop_in`=0 → read pointer advances, count−1.
- Simultaneous enqueue and dequeue: count unchanged, legal at every occupancy.
  - At full, the dequeue frees the slot in the same cycle, so the write is accepted.
- Full with no dequeue → incoming flit is dropped and `overflow_out` set; it is cleared only by reset.
- Ack/nack stop: `stop_out` is registered. It is 1 when next-cycle count ≥ Depth−1, which leaves one skid entry for a flit already launched.
- Credit: `credit_out` is registered and goes 1 the cycle after each dequeue. Upstream starts with Depth credits.

## Timing
- Reset values: `stop_out`=0, `credit_out`=0, `data_void_out`=1, `route_out`=0, `overflow_out`=0, pointers/count=0, route latch=0.
- Latency: a flit written at edge t appears on `data_out` after edge t; enqueue-to-present is 1 cycle.
- `route_out`, `data_out` and `data_void_out` are combinational from FIFO/registers only; there is no path from `data_in`.
- `stop_in` affects only the pop at the next edge; `data_out` is stable while `stop_in`=1.
- Pointers wrap modulo Depth.
- Reset asserted mid-packet: FIFO flushed and route latch cleared. The first flit accepted after reset must be a head flit; a non-head first flit is forwarded with route 0. Upstream must not send such a flit.

## Configuration
- `NOC_RING_SHORTEST_PATH_EN`
  - Defined: d ≤ N/2 → `goEast`, else `goWest` (tie at 32 goes East).
  - Undefined: every non-local route is `goEast` (unidirectional ring); West buffers only ever receive locally-destined traffic.

## Structure
- Added to the shared `noc` package:
  - `ringSize` = xMax·yMax
  - `ringIdxWidth` = $clog2(ringSize)
  - function `xy2ring_idx(xy_t)`
  - function `ring_route(cur, dst)` returning `direction_t`
- Sub-module `noc_fifo` (Depth, DataWidth; push/pop/full/empty/count) is reused by the NI queues. Route logic and flow control stay in this block.

## Test plan
- position=(x0,y0), head flit to (3,0) with ringSize 64, macro on → `route_out`=`goEast`. Dest (x0,y0) → `goLocal`. Dest idx 40 → `goWest`.
- Same idx 40 case with macro off → `goEast`.
- 3-flit packet head/body/tail with `stop_in`=1 for 2 cycles mid-packet → all three flits out in order with the same route, no loss.
- Ack/nack, Depth 4, `stop_in`=1, five back-to-back flits:
  - `stop_out` rises after the 3rd accepted flit.
  - The 4th flit is accepted.
  - The 5th (stop ignored) is dropped and `overflow_out`=1.
- Credit mode, 4 flits in, then continuous pop → `data_void_out` falls 1 cycle after the first write; exactly 4 `credit_out` pulses, each 1 cycle after its pop.
- FIFO full with simultaneous push+pop → count stays 4, no overflow. `rst` low mid-packet → all outputs return to reset values asynchronously.
